// File: rtl/uart_tx_pkg.sv
// Shared state encoding, counter widths and default parameters for the UART TX scheduler.
package uart_tx_pkg;

  localparam int unsigned N_SRC_DEF   = 4;
  localparam int unsigned GAP_DEF     = 16;
  localparam int unsigned TIMEOUT_DEF = 4095;

  localparam int unsigned GAP_CNT_W = 8;
  localparam int unsigned TO_CNT_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin picker: one-hot winner, searching upward from pointer and wrapping.
module rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned N     = N_SRC_DEF,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     winner
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // Prefer requesters at or above the pointer; otherwise fall back to the lowest index.
  always_comb begin
    mask   = ~((N'(1) << pointer) - N'(1));
    masked = req & mask;
    pick   = (masked != '0) ? masked : req;
    winner = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_SRC frame requesters with round-robin,
// inter-frame gap enforcement and a completion timeout.
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int unsigned N_SRC   = N_SRC_DEF,
  parameter int unsigned GAP     = GAP_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [3:0]         switch,
  input  logic               TXDone,
  output logic               RQ,
  output logic [7:0]         data,
  output logic [N_SRC-1:0]   grant,
  output logic [N_SRC-1:0]   done,
  output logic [N_SRC-1:0]   err,
  output logic               busy
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                 state_q, state_d;
  logic                   rq_q, rq_d;
  logic [N_SRC-1:0]       grant_q, grant_d;
  logic [N_SRC-1:0]       done_q, done_d;
  logic [N_SRC-1:0]       err_q, err_d;
  logic                   busy_q, busy_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                   txdone_q, txdone_d;

  logic [N_SRC-1:0]       win;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       ptr_next;
  logic                   txdone_rise;

  // The byte index is decoded by the sources themselves; it is routed to them outside this block.
  logic                   unused_switch;
  assign unused_switch = ^switch;

  rr_arbiter #(
    .N     (N_SRC),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req     (req),
    .pointer (ptr_q),
    .winner  (win)
  );

  // Encode the winner and derive the next highest-priority source.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
    ptr_next = (win_idx == PTR_W'(N_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  assign txdone_rise = TXDone & ~txdone_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rq_d      = rq_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = '0;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    txdone_d  = TXDone;

    case (state_q)
      ST_IDLE: begin
        gap_cnt_d = '0;
        to_cnt_d  = '0;
        // A transmitter still finishing a frame (e.g. after reset) blocks new starts.
        if ((req != '0) && !TXDone) begin
          grant_d = win;
          rq_d    = 1'b1;
          ptr_d   = ptr_next;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (txdone_rise) begin
          rq_d      = 1'b0;
          done_d    = grant_q;
          gap_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_GAP;
        end else if (to_cnt_q >= TO_LAST) begin
          rq_d      = 1'b0;
          err_d     = grant_q;
          gap_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_GAP;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_GAP: begin
        rq_d = 1'b0;
        if ((gap_cnt_q >= GAP_LAST) && !TXDone) begin
          grant_d   = '0;
          gap_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_IDLE;
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end
      default: begin
        rq_d    = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rq_q      <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      txdone_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rq_q      <= rq_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      txdone_q  <= txdone_d;
    end
  end

  // Byte mux follows the current owner; zero when nobody holds the transmitter.
  always_comb begin
    data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      data = data | (src_data[8*i +: 8] & {8{grant_q[i]}});
    end
  end

  assign RQ    = rq_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a transaction-level reference model.
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int GAPC = 16;
  localparam int TO   = 4095;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] src_data;
  logic [3:0]     switch;
  logic           TXDone;
  logic           RQ;
  logic [7:0]     data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;   // model: source with highest priority next

  uart_tx_scheduler #(.N_SRC(N), .GAP(GAPC), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .src_data (src_data),
    .switch   (switch),
    .TXDone   (TXDone),
    .RQ       (RQ),
    .data     (data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First requesting source at or after p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    int s;
    pick = -1;
    for (int k = N - 1; k >= 0; k--) begin
      s = (p + k) % N;
      if (r[s]) pick = s;
    end
  endfunction

  function automatic logic [3:0] oh(input int w);
    logic [3:0] v;
    v = 4'b0001 << w;
    return v;
  endfunction

  // Present a request pattern in IDLE and check the grant one edge later.
  task automatic start_frame(input logic [3:0] rv, input logic [31:0] sd, output int w);
    logic [31:0] bytes;
    src_data = sd;
    req      = rv;
    switch   = 4'($urandom);
    w        = pick(rv, ptr_m);
    @(negedge clk);
    bytes = sd >> (8 * w);
    chk("grant", 32'(grant), 32'(oh(w)));
    chk("rq_start", 32'(RQ), 32'd1);
    chk("busy_send", 32'(busy), 32'd1);
    chk("data_mux", 32'(data), 32'(bytes[7:0]));
    ptr_m = (w + 1) % N;
  endtask

  // Play the transmitter from SEND cycle 1 through the gap back to IDLE.
  task automatic finish_frame(input int w, input int dly, input bit to_mode, input int hold, input bit drop);
    int jx;
    if (drop) req[w] = 1'b0;
    if (to_mode) begin
      repeat (TO - 1) @(negedge clk);
      chk("rq_pre_to", 32'(RQ), 32'd1);
      chk("err_pre_to", 32'(err), 32'd0);
      @(negedge clk);
      chk("err_pulse", 32'(err), 32'(oh(w)));
      chk("done_none", 32'(done), 32'd0);
      chk("rq_after_to", 32'(RQ), 32'd0);
      hold = 0;
    end else begin
      repeat (dly) @(negedge clk);
      chk("rq_hold", 32'(RQ), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      TXDone = 1'b1;
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(oh(w)));
      chk("err_none", 32'(err), 32'd0);
      chk("rq_after_done", 32'(RQ), 32'd0);
    end
    chk("grant_gap", 32'(grant), 32'(oh(w)));
    // Gap ends after GAPC cycles and only once TXDone has been seen low.
    jx = (hold + 1 > GAPC) ? hold + 1 : GAPC;
    for (int t = 0; t < jx; t++) begin
      if (t == hold) TXDone = 1'b0;
      @(negedge clk);
      if (t + 1 < jx)
        chk("in_gap", 32'({busy, RQ, done, err, grant}), 32'({1'b1, 1'b0, 4'b0, 4'b0, oh(w)}));
    end
    chk("idle_after_gap", 32'({busy, RQ, grant}), 32'd0);
    chk("data_idle", 32'(data), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    reset    = 1'b0;
    req      = '0;
    src_data = '0;
    switch   = '0;
    TXDone   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({RQ, busy, grant, done, err}), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_noreq", 32'({RQ, busy, grant}), 32'd0);

    // Contention: all sources held, rotating order starting at source 0.
    for (int f = 0; f < 5; f++) begin
      start_frame(4'b1111, $urandom, w);
      finish_frame(w, int'($urandom_range(0, 6)), 1'b0, int'($urandom_range(0, 4)), 1'b0);
    end

    // Single requester.
    start_frame(4'b0100, $urandom, w);
    finish_frame(w, 3, 1'b0, 2, 1'b0);

    // Directed data mux value from source 1.
    start_frame(4'b0010, 32'h1234_A578, w);
    chk("data_a5", 32'(data), 32'h0000_00A5);
    finish_frame(w, 1, 1'b0, 0, 1'b0);

    // Timeout, then the next requester is served.
    start_frame(4'b1111, $urandom, w);
    finish_frame(w, 0, 1'b1, 0, 1'b0);
    start_frame(4'b1111, $urandom, w);

    // Stuck TXDone keeps the scheduler in the gap.
    finish_frame(w, 2, 1'b0, 30, 1'b0);

    // Randomised traffic including requests dropped mid-frame.
    for (int f = 0; f < 20; f++) begin
      start_frame(4'($urandom_range(1, 15)), $urandom, w);
      finish_frame(w, int'($urandom_range(0, 20)), 1'b0, int'($urandom_range(0, 25)),
                   1'($urandom_range(0, 1)));
    end

    // Reset in the middle of SEND while the transmitter keeps TXDone high.
    start_frame(4'b0100, $urandom, w);
    @(negedge clk);
    reset  = 1'b0;
    TXDone = 1'b1;
    #1;
    chk("async_reset", 32'({RQ, grant, busy}), 32'd0);
    ptr_m = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_rq_txdone_high", 32'({RQ, grant, busy}), 32'd0);
    end
    TXDone = 1'b0;
    start_frame(4'b1111, $urandom, w);
    chk("post_reset_src0", 32'(w), 32'd0);
    finish_frame(w, 4, 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of frame requesters sharing one 15-byte UART transmitter.
REQ-002 SHALL have parameter GAP, default 16, minimum idle cycles with RQ low between frames (8-bit counter).
REQ-003 SHALL have parameter TIMEOUT, default 4095, maximum cycles RQ is held waiting for TXDone (12-bit counter).
REQ-004 SHALL have port clk, input, 1, transmitter baud clock; all logic rises on posedge clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_SRC, level frame request per source, held until done or err.
REQ-007 SHALL have port src_data, input, 8*N_SRC, byte from source i on bits [8i+7:8i].
REQ-008 SHALL have port switch, input, 4, byte index from the transmitter, forwarded to sources unchanged.
REQ-009 SHALL have port TXDone, input, 1, frame-complete level from the transmitter.
REQ-010 SHALL have port RQ, output, 1, start request to the transmitter.
REQ-011 SHALL have port data, output, 8, muxed byte to the transmitter.
REQ-012 SHALL have port grant, output, N_SRC, one-hot owner of the transmitter, zero when idle.
REQ-013 SHALL have port done, output, N_SRC, one-cycle pulse on the granted bit at frame completion.
REQ-014 SHALL have port err, output, N_SRC, one-cycle pulse on the granted bit at timeout.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP.
REQ-017 IDLE: when req is non-zero, SHALL register the one-hot grant of the round-robin winner, set RQ=1, and enter SEND on the next edge (1-cycle latency from req to RQ).
REQ-018 Round-robin: highest priority SHALL be the source after the last granted one; after reset, source 0 is highest.
REQ-019 data SHALL equal src_data of the granted source combinationally, and 8'h00 when grant is zero.
REQ-020 SEND: SHALL count cycles and detect the rising edge of TXDone using a registered copy.
REQ-021 On a TXDone rising edge in SEND, SHALL clear RQ, pulse done[granted] for one cycle, and enter GAP.
REQ-022 If the counter reaches TIMEOUT in SEND without a TXDone edge, SHALL clear RQ, pulse err[granted] for one cycle, and enter GAP.
REQ-023 GAP: SHALL hold RQ=0 and the grant, and leave for IDLE (clearing grant) only after GAP cycles have elapsed AND TXDone is low.
REQ-024 If req[granted] falls during SEND, the frame SHALL continue to completion; the transmitter cannot abort.
REQ-025 A source that still asserts req in IDLE SHALL be treated as a new request, subject to round-robin.
REQ-026 A TXDone edge observed outside SEND SHALL be ignored.
REQ-027 Counters SHALL saturate and never wrap; both reset to 0 on every state entry.

Reset
REQ-028 While reset is low, SHALL force RQ=0, grant=0, done=0, err=0, busy=0, state IDLE, round-robin pointer to source 0, and counters and the TXDone register to 0.
REQ-029 Reset asserted mid-SEND SHALL drop RQ immediately; the transmitter then finishes its own cycle. After release, the scheduler SHALL wait in GAP-free IDLE but SHALL not issue RQ while TXDone is high.

Structure
REQ-030 Shared package uart_tx_pkg SHALL hold the state encoding constants and the N_SRC, GAP, and TIMEOUT defaults.
REQ-031 The round-robin picker SHALL be a separate sub-module rr_arbiter with inputs req and pointer, and a one-hot winner output.
REQ-032 Target size is 120-400 RTL lines including rr_arbiter.

Verification
REQ-033 Single request: req=4'b0100 -> next edge grant=0100, RQ=1; transmitter model TXDone edge -> done=0100 for 1 cycle, RQ=0, then IDLE after 16 cycles.
REQ-034 Contention: req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each separated by at least 16 RQ-low cycles.
REQ-035 Data mux: grant=0010 with src_data[15:8]=8'hA5 -> data=8'hA5; when idle -> data=8'h00.
REQ-036 Timeout: model never raises TXDone -> err pulse on the granted bit at cycle 4095 of SEND, RQ=0, then the next requester is served.
REQ-037 Stuck TXDone: TXDone held high past GAP -> state stays in GAP until TXDone is low, with no RQ.
REQ-038 Reset mid-SEND: reset low for 3 cycles -> RQ, grant, and busy are 0 asynchronously; after release, the next grant goes to source 0 first.
